// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor (PHT of saturating counters indexed by PC ^ GHR) with a tagged BTB.
// Define BP_PERF_CNT_EN to add the BranchCount / MispredCount performance counters.
module branch_predictor_gshare #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int GHR_BITS = 6,
  parameter int CTR_BITS = 2,
  parameter int TAG_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     PCF,
  input  logic [1:0]          InstrF,
  output logic [XLEN-1:0]     PredPCTargetF,
  output logic                PCSrcPredF,
  output logic [IDX_BITS-1:0] PredIdxF,
  input  logic                StallE,
  input  logic                BranchValidE,
  input  logic [XLEN-1:0]     PCE,
  input  logic [IDX_BITS-1:0] PredIdxE,
  input  logic                PCSrcPredE,
  input  logic                BranchTakenE,
  input  logic [XLEN-1:0]     PCTargetE,
  output logic                TargetMatchE,
  output logic                MispredictE
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]         BranchCount,
  output logic [31:0]         MispredCount
`endif
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam int GW    = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0] pht_q [DEPTH];
  logic [CTR_BITS-1:0] pht_d [DEPTH];
  logic                btb_valid_q [DEPTH];
  logic                btb_valid_d [DEPTH];
  logic [TAG_BITS-1:0] btb_tag_q [DEPTH];
  logic [TAG_BITS-1:0] btb_tag_d [DEPTH];
  logic [XLEN-1:0]     btb_tgt_q [DEPTH];
  logic [XLEN-1:0]     btb_tgt_d [DEPTH];
  logic [GW-1:0]       ghr_q, ghr_d;

  logic [IDX_BITS-1:0] bidx_f, fidx_f, ghr_idx, eidx;
  logic [TAG_BITS-1:0] ftag, etag;
  logic                btb_hit_f, btb_hit_e, upd;

  assign bidx_f = PCF[IDX_BITS+1:2];
  assign ftag   = PCF[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign eidx   = PCE[IDX_BITS+1:2];
  assign etag   = PCE[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd    = BranchValidE & ~StallE & reset;

  always_comb begin
    ghr_idx       = (GHR_BITS > 0) ? IDX_BITS'(ghr_q) : '0;
    fidx_f        = bidx_f ^ ghr_idx;
    PredIdxF      = fidx_f;
    btb_hit_f     = btb_valid_q[bidx_f] && (btb_tag_q[bidx_f] == ftag);
    PCSrcPredF    = (InstrF == 2'b11) && btb_hit_f && pht_q[fidx_f][CTR_BITS-1];
    PredPCTargetF = btb_hit_f ? btb_tgt_q[bidx_f] : '0;
    btb_hit_e     = btb_valid_q[eidx] && (btb_tag_q[eidx] == etag);
    TargetMatchE  = btb_hit_e && (btb_tgt_q[eidx] == PCTargetE);
    MispredictE   = BranchValidE && ((BranchTakenE != PCSrcPredE) ||
                                     (BranchTakenE && PCSrcPredE && !TargetMatchE));
  end

  // Training: writes land at the edge, so a same-cycle Fetch read sees the old entry.
  always_comb begin
    pht_d       = pht_q;
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    ghr_d       = ghr_q;
    if (upd) begin
      if (BranchTakenE && (pht_q[PredIdxE] != CTR_MAX))
        pht_d[PredIdxE] = pht_q[PredIdxE] + CTR_BITS'(1);
      else if (!BranchTakenE && (pht_q[PredIdxE] != '0))
        pht_d[PredIdxE] = pht_q[PredIdxE] - CTR_BITS'(1);
      if (BranchTakenE) begin
        btb_valid_d[eidx] = 1'b1;
        btb_tag_d[eidx]   = etag;
        btb_tgt_d[eidx]   = PCTargetE;
      end
      if (GHR_BITS > 0)
        ghr_d = (ghr_q << 1) | GW'(BranchTakenE);
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q + 32'(upd);
    mispred_cnt_d = mispred_cnt_q + 32'(upd & MispredictE);
  end

  assign BranchCount  = branch_cnt_q;
  assign MispredCount = mispred_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pht_q[i]       <= CTR_INIT;
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
      end
      ghr_q <= '0;
`ifdef BP_PERF_CNT_EN
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
`endif
    end else begin
      pht_q       <= pht_d;
      btb_valid_q <= btb_valid_d;
      btb_tag_q   <= btb_tag_d;
      btb_tgt_q   <= btb_tgt_d;
      ghr_q       <= ghr_d;
`ifdef BP_PERF_CNT_EN
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
`endif
    end
  end

endmodule
